// File: rtl/reorder_buf.sv
// rtl/reorder_buf.sv - completion reorder buffer: per-tag slot reservation, out-of-order fill, in-order drain
// Slots are reserved at allocation, filled by completion beats, and drained in allocation order.
module reorder_buf #(
   parameter int W         = 128,
   parameter int LOG_DEPTH = 9,
   parameter int TAG_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 alloc_valid,
   input  logic [TAG_W-1:0]     alloc_tag,
   input  logic [LOG_DEPTH:0]   alloc_len,
   output logic                 alloc_ready,
   input  logic                 cpl_valid,
   input  logic                 cpl_sof,
   input  logic [TAG_W-1:0]     cpl_tag,
   input  logic [LOG_DEPTH-1:0] cpl_offset,
   input  logic [W-1:0]         cpl_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [W-1:0]         out_data,
   output logic [TAG_W-1:0]     out_tag,
   output logic                 out_last,
   output logic [LOG_DEPTH:0]   free_count,
   output logic                 err
);

   localparam int DEPTH = 1 << LOG_DEPTH;
   localparam int NTAG  = 1 << TAG_W;
   localparam int SW    = W + TAG_W + 1;
   localparam logic [LOG_DEPTH:0]   CNT_ONE   = {{LOG_DEPTH{1'b0}}, 1'b1};
   localparam logic [LOG_DEPTH:0]   CNT_DEPTH = {1'b1, {LOG_DEPTH{1'b0}}};
   localparam logic [LOG_DEPTH-1:0] PTR_ONE   = {{(LOG_DEPTH-1){1'b0}}, 1'b1};

   logic [LOG_DEPTH-1:0] ap;
   logic [LOG_DEPTH-1:0] rp;
   logic [LOG_DEPTH:0]   free_cnt;
   logic                 err_q;

   logic [LOG_DEPTH-1:0] base_tbl [NTAG];
   logic [LOG_DEPTH:0]   len_tbl  [NTAG];
   logic [SW-1:0]        slot_mem [DEPTH];
   logic [DEPTH-1:0]     slot_vld;

   logic [TAG_W-1:0]     cur_tag_q;
   logic [LOG_DEPTH:0]   nxt_off_q;
   logic [TAG_W-1:0]     cur_tag;
   logic [LOG_DEPTH:0]   cur_off;
   logic [LOG_DEPTH-1:0] cur_base;
   logic [LOG_DEPTH:0]   cur_len;
   logic [LOG_DEPTH-1:0] wr_addr;
   logic                 wr_last;
   logic                 off_bad;
   logic                 slot_hit;
   logic                 wr_en;
   logic                 wr_err;

   logic                 alloc_fire;
   logic                 pop;
   logic                 issue;
   logic [1:0]           occ;

   logic                 s1_vld;
   logic [SW-1:0]        s1_word;
   logic [SW-1:0]        sk_mem [2];
   logic                 sk_wp;
   logic                 sk_rp;
   logic [1:0]           sk_cnt;

   assign alloc_ready = (alloc_len != '0) && (alloc_len <= free_cnt);
   assign alloc_fire  = alloc_valid && alloc_ready;
   assign free_count  = free_cnt;
   assign err         = err_q;

   // Non-sof beats continue the packet using the latched tag and running offset
   assign cur_tag  = cpl_sof ? cpl_tag : cur_tag_q;
   assign cur_off  = cpl_sof ? {1'b0, cpl_offset} : nxt_off_q;
   assign cur_base = base_tbl[cur_tag];
   assign cur_len  = len_tbl[cur_tag];
   assign wr_addr  = cur_base + cur_off[LOG_DEPTH-1:0];
   assign wr_last  = (cur_off == (cur_len - CNT_ONE));
   assign off_bad  = (cur_off >= cur_len);
   assign slot_hit = slot_vld[wr_addr];
   assign wr_en    = cpl_valid && !off_bad && !slot_hit;
   assign wr_err   = cpl_valid && (off_bad || slot_hit);

   // Read credit: in-flight RAM read plus skid occupancy must never exceed two
   assign pop   = out_valid && out_ready;
   assign occ   = {1'b0, s1_vld} + sk_cnt - {1'b0, pop};
   assign issue = slot_vld[rp] && (occ < 2'd2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ap        <= '0;
         free_cnt  <= CNT_DEPTH;
         err_q     <= 1'b0;
         cur_tag_q <= '0;
         nxt_off_q <= '0;
      end else begin
         if (alloc_fire) begin
            ap <= ap + alloc_len[LOG_DEPTH-1:0];
         end
         free_cnt <= free_cnt - (alloc_fire ? alloc_len : '0) + (pop ? CNT_ONE : '0);
         if (wr_err) begin
            err_q <= 1'b1;
         end
         if (cpl_valid) begin
            cur_tag_q <= cur_tag;
            nxt_off_q <= cur_off + CNT_ONE;
         end
      end
   end

   // A write never targets rp while it is being issued: that slot is valid, so the write is an error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_vld <= '0;
         rp       <= '0;
         s1_vld   <= 1'b0;
      end else begin
         if (wr_en) begin
            slot_vld[wr_addr] <= 1'b1;
         end
         if (issue) begin
            slot_vld[rp] <= 1'b0;
            rp           <= rp + PTR_ONE;
         end
         s1_vld <= issue;
      end
   end

   always_ff @(posedge clk) begin
      if (alloc_fire) begin
         base_tbl[alloc_tag] <= ap;
         len_tbl[alloc_tag]  <= alloc_len;
      end
      if (wr_en) begin
         slot_mem[wr_addr] <= {cpl_data, cur_tag, wr_last};
      end
      if (issue) begin
         s1_word <= slot_mem[rp];
      end
   end

   // Two-entry skid; the head entry is the output and is never overwritten while held
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            sk_mem[i] <= '0;
         end
         sk_wp  <= 1'b0;
         sk_rp  <= 1'b0;
         sk_cnt <= 2'd0;
      end else begin
         if (s1_vld) begin
            sk_mem[sk_wp] <= s1_word;
            sk_wp         <= ~sk_wp;
         end
         if (pop) begin
            sk_rp <= ~sk_rp;
         end
         sk_cnt <= sk_cnt + {1'b0, s1_vld} - {1'b0, pop};
      end
   end

   assign out_valid = (sk_cnt != 2'd0);
   assign out_data  = sk_mem[sk_rp][SW-1 -: W];
   assign out_tag   = sk_mem[sk_rp][TAG_W:1];
   assign out_last  = sk_mem[sk_rp][0];

endmodule

// File: tb/tb_reorder_buf.sv
// tb/tb_reorder_buf.sv - randomized bench for reorder_buf against an allocation-level reference model
module tb_reorder_buf;

   localparam int W     = 128;
   localparam int LD    = 9;
   localparam int TW    = 8;
   localparam int DEPTH = 512;

   logic          clk;
   logic          rst_n;
   logic          alloc_valid;
   logic [TW-1:0] alloc_tag;
   logic [LD:0]   alloc_len;
   logic          alloc_ready;
   logic          cpl_valid;
   logic          cpl_sof;
   logic [TW-1:0] cpl_tag;
   logic [LD-1:0] cpl_offset;
   logic [W-1:0]  cpl_data;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic [TW-1:0] out_tag;
   logic          out_last;
   logic [LD:0]   free_count;
   logic          err;

   reorder_buf #(.W(W), .LOG_DEPTH(LD), .TAG_W(TW)) dut (
      .clk(clk), .rst_n(rst_n),
      .alloc_valid(alloc_valid), .alloc_tag(alloc_tag), .alloc_len(alloc_len), .alloc_ready(alloc_ready),
      .cpl_valid(cpl_valid), .cpl_sof(cpl_sof), .cpl_tag(cpl_tag), .cpl_offset(cpl_offset), .cpl_data(cpl_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag), .out_last(out_last),
      .free_count(free_count), .err(err)
   );

   typedef struct {
      int tag;
      int base;
      int len;
   } alloc_t;

   // Reference model: allocation list in order, slot contents, free count, sticky error
   alloc_t        aq[$];
   int            m_beat;
   int            m_free;
   int            m_ap;
   bit            m_err;
   logic [W-1:0]  slot_data [DEPTH];
   bit            slot_wr [DEPTH];
   int            m_base [256];
   int            m_len [256];

   int n_checks;
   int n_errors;
   int cyc;
   int first_valid_cyc;
   int pkt_cyc;
   int rdy_mode;
   bit mon_en;
   bit alloc_done;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0: out_ready = 1'b1;
         1: out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b0;
      endcase
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] rnd_data();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic model_clear();
      aq.delete();
      m_beat = 0;
      m_free = DEPTH;
      m_ap   = 0;
      m_err  = 1'b0;
      for (int i = 0; i < DEPTH; i++) slot_wr[i] = 1'b0;
   endtask

   task automatic m_write(input int tag, input int off, input logic [W-1:0] d);
      int s;
      if (off >= m_len[tag]) begin
         m_err = 1'b1;
      end else begin
         s = (m_base[tag] + off) % DEPTH;
         if (slot_wr[s]) m_err = 1'b1;
         else begin
            slot_wr[s]   = 1'b1;
            slot_data[s] = d;
         end
      end
   endtask

   always @(negedge clk) begin : monitor
      alloc_t h;
      int     s;
      bit     exp_rdy;
      if (mon_en && rst_n) begin
         chk("free_count", free_count, m_free);
         exp_rdy = (alloc_len != 0) && (int'(alloc_len) <= m_free);
         chk("alloc_ready", alloc_ready, exp_rdy);
         if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (aq.size() == 0) begin
            chk("out_valid_empty", out_valid, 0);
         end else begin
            h = aq[0];
            s = (h.base + m_beat) % DEPTH;
            if (!slot_wr[s]) begin
               chk("out_early", out_valid, 0);
            end else if (out_valid) begin
               chk("out_data", out_data, slot_data[s]);
               chk("out_tag", out_tag, h.tag);
               chk("out_last", out_last, (m_beat == h.len - 1));
               if (out_ready) begin
                  slot_wr[s] = 1'b0;
                  m_free++;
                  m_beat++;
                  if (m_beat == h.len) begin
                     void'(aq.pop_front());
                     m_beat = 0;
                  end
               end
            end
         end
         if (alloc_valid && exp_rdy) begin
            m_base[alloc_tag] = m_ap;
            m_len[alloc_tag]  = int'(alloc_len);
            aq.push_back('{tag: int'(alloc_tag), base: m_ap, len: int'(alloc_len)});
            m_ap   = (m_ap + int'(alloc_len)) % DEPTH;
            m_free = m_free - int'(alloc_len);
            alloc_done = 1'b1;
         end
      end
   end

   task automatic do_alloc(input int tag, input int len);
      @(posedge clk);
      #1;
      alloc_done  = 1'b0;
      alloc_valid = 1'b1;
      alloc_tag   = TW'(tag);
      alloc_len   = (LD + 1)'(len);
      for (int i = 0; i < 3000 && !alloc_done; i++) @(posedge clk);
      if (!alloc_done) chk("alloc_timeout", alloc_done, 1);
      #1;
      alloc_valid = 1'b0;
      alloc_len   = '0;
   endtask

   // One packet: sof beat carries tag/offset, later beats carry junk there
   task automatic send_pkt(input int tag, input int off, input int n, input logic [W-1:0] d0, input bit rnd);
      logic [W-1:0] d;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         d = rnd ? rnd_data() : d0 + W'(i);
         if (i == 0) pkt_cyc = cyc;
         cpl_valid  = 1'b1;
         cpl_sof    = (i == 0);
         cpl_tag    = (i == 0) ? TW'(tag) : TW'($urandom);
         cpl_offset = (i == 0) ? LD'(off) : LD'($urandom);
         cpl_data   = d;
         m_write(tag, off + i, d);
      end
      @(posedge clk);
      #1;
      cpl_valid = 1'b0;
      cpl_sof   = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 5000 && aq.size() != 0; i++) @(posedge clk);
      chk("drain_left", aq.size(), 0);
      repeat (2) @(posedge clk);
      #1;
      chk("idle_free", free_count, DEPTH);
      chk("idle_valid", out_valid, 0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3;
      mon_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_tag", out_tag, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_err", err, 0);
      model_clear();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_free", free_count, DEPTH);
      mon_en = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int ntag, len, s, k;
      int tags[4];
      int lens[4];
      int ord[4];
      logic [W-1:0] keep;
      n_checks = 0; n_errors = 0; cyc = 0; rdy_mode = 0; mon_en = 1'b0;
      first_valid_cyc = -1; pkt_cyc = 0; alloc_done = 1'b0;
      alloc_valid = 1'b0; alloc_tag = '0; alloc_len = '0;
      cpl_valid = 1'b0; cpl_sof = 1'b0; cpl_tag = '0; cpl_offset = '0; cpl_data = '0;
      out_ready = 1'b1;
      model_clear();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_data", out_data, 0);
      chk("reset_out_tag", out_tag, 0);
      chk("reset_out_last", out_last, 0);
      chk("reset_err", err, 0);
      chk("reset_free", free_count, DEPTH);
      rst_n = 1'b1;
      alloc_len = 1;
      #1;
      chk("reset_ready_len1", alloc_ready, 1);
      alloc_len = 0;
      #1;
      chk("reset_ready_len0", alloc_ready, 0);
      mon_en = 1'b1;

      // In-order basic transfer and pipeline latency
      do_alloc(1, 4);
      send_pkt(1, 0, 4, W'('hA0), 1'b0);
      wait_drain();
      chk("first_latency", first_valid_cyc - (pkt_cyc), 3);

      // Later tag completes first
      do_alloc(1, 2);
      do_alloc(2, 2);
      send_pkt(2, 0, 2, '0, 1'b1);
      send_pkt(1, 1, 1, '0, 1'b1);
      send_pkt(1, 0, 1, '0, 1'b1);
      wait_drain();

      do_reset();

      // Wrap-around allocation with a long output stall
      do_alloc(3, 510);
      fork
         send_pkt(3, 0, 510, '0, 1'b1);
         begin
            repeat (150) @(posedge clk);
            rdy_mode = 2;
            repeat (20) @(posedge clk);
            rdy_mode = 0;
         end
      join
      do_alloc(4, 4);
      rdy_mode = 2;
      send_pkt(4, 2, 2, '0, 1'b1);
      send_pkt(4, 0, 2, '0, 1'b1);
      repeat (20) @(posedge clk);
      rdy_mode = 0;
      wait_drain();

      // Full buffer: a len-1 request waits for the first pop
      do_alloc(6, DEPTH);
      chk("full_free", free_count, 0);
      alloc_len = 1;
      #1;
      chk("full_ready", alloc_ready, 0);
      fork
         do_alloc(7, 1);
         begin
            repeat (4) @(posedge clk);
            send_pkt(6, 0, 1, '0, 1'b1);
         end
      join
      send_pkt(6, 1, DEPTH - 1, '0, 1'b1);
      send_pkt(7, 0, 1, '0, 1'b1);
      wait_drain();

      // Protocol errors: duplicate slot write and offset past length
      do_alloc(5, 3);
      keep = rnd_data();
      send_pkt(5, 1, 1, keep, 1'b0);
      chk("err_clean", err, m_err);
      send_pkt(5, 1, 1, ~keep, 1'b0);
      chk("err_dup", err, m_err);
      send_pkt(5, 5, 1, '0, 1'b1);
      chk("err_ovr", err, m_err);
      send_pkt(5, 0, 1, '0, 1'b1);
      send_pkt(5, 2, 1, '0, 1'b1);
      wait_drain();
      chk("err_sticky", err, m_err);

      // Random allocations completed in random order under random backpressure
      rdy_mode = 1;
      for (int r = 0; r < 12; r++) begin
         ntag = $urandom_range(1, 4);
         for (int j = 0; j < ntag; j++) begin
            tags[j] = 16 + r * 4 + j;
            lens[j] = $urandom_range(1, 24);
            ord[j]  = j;
            do_alloc(tags[j], lens[j]);
         end
         for (int j = ntag - 1; j > 0; j--) begin
            k = $urandom_range(0, j);
            s = ord[j]; ord[j] = ord[k]; ord[k] = s;
         end
         for (int j = 0; j < ntag; j++) begin
            len = lens[ord[j]];
            if (len > 1 && $urandom_range(0, 1) == 1) begin
               s = $urandom_range(1, len - 1);
               send_pkt(tags[ord[j]], s, len - s, '0, 1'b1);
               send_pkt(tags[ord[j]], 0, s, '0, 1'b1);
            end else begin
               send_pkt(tags[ord[j]], 0, len, '0, 1'b1);
            end
         end
      end
      rdy_mode = 0;
      wait_drain();

      // Reset while data sits in the output pipeline
      do_alloc(9, 8);
      rdy_mode = 2;
      send_pkt(9, 0, 8, '0, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      chk("pre_reset_valid", out_valid, 1);
      do_reset();
      rdy_mode = 0;
      chk("post_reset_err", err, 0);
      do_alloc(1, 2);
      send_pkt(1, 0, 2, '0, 1'b1);
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
